// File: rtl/aer_event_encoder.sv
// aer_event_encoder: timestamps per-channel spikes and serialises them round-robin as AER words.
// Optional AER_DROP_CNT_EN adds a saturating drop_count output.
module aer_event_encoder #(
   parameter int NUM_CH   = 16,
   parameter int TS_WIDTH = 20
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_CH-1:0]     spike_in,
   input  logic                  aer_ready,
   input  logic                  clr_overflow,
   output logic [TS_WIDTH+3:0]   aer_out,
   output logic                  aer_valid,
   output logic                  overflow
`ifdef AER_DROP_CNT_EN
   ,
   output logic [15:0]           drop_count
`endif
);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] SEND = 1'b1;
   logic [0:0]          state;
   logic [TS_WIDTH-1:0] ts_cnt;
   logic [TS_WIDTH-1:0] ts_cap [NUM_CH];
   logic [NUM_CH-1:0]   pending, gnt_oh, drop;
   logic [3:0]          rr_ptr, gnt_ch;
   logic                gnt_any, load;
   int                  idx;
   assign aer_valid = (state == SEND);
   // Walk from the farthest offset down so the nearest pending channel at or above rr_ptr wins.
   always_comb begin
      gnt_any = 1'b0;
      gnt_ch  = '0;
      idx     = 0;
      for (int k = NUM_CH-1; k >= 0; k--) begin
         idx = (int'(rr_ptr) + k) % NUM_CH;
         if (pending[idx]) begin
            gnt_any = 1'b1;
            gnt_ch  = 4'(idx);
         end
      end
   end
   assign load   = gnt_any && (state == IDLE || aer_ready);
   assign gnt_oh = load ? (NUM_CH'(1) << gnt_ch) : '0;
   // A spike on a channel still holding an ungranted event is lost.
   assign drop   = spike_in & pending & ~gnt_oh;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ts_cnt  <= '0;
         pending <= '0;
         for (int i = 0; i < NUM_CH; i++) ts_cap[i] <= '0;
      end else begin
         ts_cnt  <= ts_cnt + TS_WIDTH'(1);
         pending <= (pending & ~gnt_oh) | spike_in;
         for (int i = 0; i < NUM_CH; i++)
            if (spike_in[i] && !drop[i]) ts_cap[i] <= ts_cnt;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         aer_out <= '0;
         rr_ptr  <= '0;
      end else if (load) begin
         state   <= SEND;
         aer_out <= {gnt_ch, ts_cap[gnt_ch]};
         rr_ptr  <= (gnt_ch == 4'(NUM_CH-1)) ? 4'd0 : gnt_ch + 4'd1;
      end else if (aer_ready) begin
         state   <= IDLE;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) overflow <= 1'b0;
      else        overflow <= (|drop) ? 1'b1 : (clr_overflow ? 1'b0 : overflow);
   end
`ifdef AER_DROP_CNT_EN
   logic [4:0]  drop_n;
   logic [16:0] cnt_sum;
   always_comb begin
      drop_n = '0;
      for (int i = 0; i < NUM_CH; i++) drop_n = drop_n + 5'(drop[i]);
      cnt_sum = (clr_overflow ? 17'd0 : {1'b0, drop_count}) + 17'(drop_n);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) drop_count <= '0;
      else        drop_count <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
   end
`endif
endmodule
